// File: rtl/divider_restoring_pkg.sv
// Shared definitions for the restoring divider: FSM encoding and counter sizing.
package divider_restoring_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Iteration counter must hold the value NW itself, hence the extra bit.
  function automatic int cnt_width(input int nw);
    return $clog2(nw) + 1;
  endfunction

endpackage

// File: rtl/divider_restoring_step.sv
// One restoring-division step: trial subtract of the divisor from the shifted partial remainder.
module div_step #(
  parameter int DW = 4
) (
  input  logic [DW:0]   t_i,
  input  logic [DW-1:0] d_i,
  output logic [DW:0]   p_next_o,
  output logic          qbit_o
);

  assign qbit_o   = (t_i >= {1'b0, d_i});
  assign p_next_o = qbit_o ? (t_i - {1'b0, d_i}) : t_i;

endmodule

// File: rtl/divider_restoring.sv
// Sequential unsigned restoring divider: one quotient bit per clock, result held with Done.
module divider_restoring
  import divider_restoring_pkg::*;
#(
  parameter int NW = 8,
  parameter int DW = 4
) (
  input  logic          Clk,
  input  logic          Resetn,
  input  logic          Start,
  input  logic [NW-1:0] Nin,
  input  logic [DW-1:0] Din,
  output logic [NW-1:0] Q,
  output logic [DW-1:0] R,
  output logic          Busy,
  output logic          Done,
  output logic          DivZero
);

  localparam int CW = cnt_width(NW);

  state_e        state_q, state_d;
  logic [NW-1:0] n_q, n_d, q_q, q_d;
  logic [DW-1:0] d_q, d_d, r_q, r_d;
  logic [DW:0]   p_q, p_d, t, p_next;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dz_q, dz_d;
  logic          qbit;
  logic          unused_p;

  // P stays below D after every step, so its top bit never feeds the next shift.
  assign unused_p = p_q[DW];
  assign t        = {p_q[DW-1:0], n_q[NW-1]};

  div_step #(.DW(DW)) u_step (
    .t_i      (t),
    .d_i      (d_q),
    .p_next_o (p_next),
    .qbit_o   (qbit)
  );

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    d_d     = d_q;
    p_d     = p_q;
    q_d     = q_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          if (Din == '0) begin
            state_d = ST_DONE;
            q_d     = '1;
            r_d     = '0;
            dz_d    = 1'b1;
          end else begin
            state_d = ST_RUN;
            n_d     = Nin;
            d_d     = Din;
            p_d     = '0;
            q_d     = '0;
            cnt_d   = CW'(NW);
            dz_d    = 1'b0;
          end
        end
      end
      ST_RUN: begin
        n_d   = n_q << 1;
        p_d   = p_next;
        q_d   = {q_q[NW-2:0], qbit};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = ST_DONE;
          r_d     = p_next[DW-1:0];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      d_q     <= '0;
      p_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      d_q     <= d_d;
      p_q     <= p_d;
      q_q     <= q_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
    end
  end

  assign Q       = q_q;
  assign R       = r_q;
  assign Busy    = (state_q == ST_RUN);
  assign Done    = (state_q == ST_DONE);
  assign DivZero = dz_q;

endmodule

// File: tb/tb_divider_restoring.sv
// Directed and swept checks of the restoring divider against hand-computed and integer results.
module tb_divider_restoring;

  logic       Clk, Resetn, Start;
  logic [7:0] Nin;
  logic [3:0] Din;
  logic [7:0] Q;
  logic [3:0] R;
  logic       Busy, Done, DivZero;

  int total = 0;
  int bad   = 0;

  divider_restoring #(.NW(8), .DW(4)) dut (
    .Clk(Clk), .Resetn(Resetn), .Start(Start), .Nin(Nin), .Din(Din),
    .Q(Q), .R(R), .Busy(Busy), .Done(Done), .DivZero(DivZero)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    total++;
    if (Busy && Done) begin
      bad++;
      $display("FAIL busy_done_exclusive: Busy=%0b Done=%0b, need not both", Busy, Done);
    end
  end

  // Issue one request and wait (bounded) for Done; counts cycles and Busy cycles.
  task automatic run_op(input logic [7:0] n, input logic [3:0] d,
                        output int cycles, output int busy_cnt, output bit tmo);
    @(negedge Clk);
    Start = 1'b1; Nin = n; Din = d;
    @(negedge Clk);
    Start = 1'b0; Nin = 8'hA5; Din = 4'h3;
    cycles = 1; busy_cnt = 0; tmo = 1'b0;
    while (!Done && cycles < 40) begin
      if (Busy) busy_cnt++;
      @(negedge Clk);
      cycles++;
    end
    if (!Done) tmo = 1'b1;
  endtask

  task automatic test_reset();
    Resetn = 1'b0; Start = 1'b0; Nin = '0; Din = '0;
    repeat (2) @(negedge Clk);
    total++;
    if ({Q, R, Busy, Done, DivZero} !== 15'd0) begin
      bad++;
      $display("FAIL reset_outputs: Q=%0d R=%0d B=%0b D=%0b Z=%0b, need all 0", Q, R, Busy, Done, DivZero);
    end
    Resetn = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_basic();
    int c, b; bit tmo;
    run_op(8'd100, 4'd7, c, b, tmo);
    total++;
    if (tmo || c != 9 || b != 8) begin
      bad++;
      $display("FAIL basic_latency: done_cycle=%0d busy=%0d tmo=%0b, need 9 and 8", c, b, tmo);
    end
    total++;
    if (Q !== 8'd14 || R !== 4'd2 || DivZero !== 1'b0) begin
      bad++;
      $display("FAIL basic_result: Q=%0d R=%0d Z=%0b, need 14 2 0", Q, R, DivZero);
    end
  endtask

  task automatic test_vectors();
    logic [7:0] vn [4] = '{8'd255, 8'd0,  8'd5, 8'd255};
    logic [3:0] vd [4] = '{4'd1,   4'd15, 4'd9, 4'd15};
    logic [7:0] eq [4] = '{8'd255, 8'd0,  8'd0, 8'd17};
    logic [3:0] er [4] = '{4'd0,   4'd0,  4'd5, 4'd0};
    int c, b; bit tmo;
    for (int i = 0; i < 4; i++) begin
      run_op(vn[i], vd[i], c, b, tmo);
      total++;
      if (tmo || Q !== eq[i] || R !== er[i] || DivZero !== 1'b0) begin
        bad++;
        $display("FAIL vector_%0d: %0d/%0d gave Q=%0d R=%0d tmo=%0b, need Q=%0d R=%0d",
                 i, vn[i], vd[i], Q, R, tmo, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_divzero();
    int c, b; bit tmo;
    run_op(8'd200, 4'd0, c, b, tmo);
    total++;
    if (tmo || c != 1 || b != 0) begin
      bad++;
      $display("FAIL divzero_latency: done_cycle=%0d busy=%0d, need 1 and 0", c, b);
    end
    total++;
    if (Q !== 8'hFF || R !== 4'd0 || DivZero !== 1'b1) begin
      bad++;
      $display("FAIL divzero_result: Q=%0h R=%0d Z=%0b, need ff 0 1", Q, R, DivZero);
    end
    repeat (3) @(negedge Clk);
    total++;
    if (Done !== 1'b1 || Q !== 8'hFF || DivZero !== 1'b1) begin
      bad++;
      $display("FAIL divzero_hold: Done=%0b Q=%0h Z=%0b, need 1 ff 1", Done, Q, DivZero);
    end
  endtask

  task automatic test_start_in_run();
    int c;
    @(negedge Clk);
    Start = 1'b1; Nin = 8'd100; Din = 4'd7;
    @(negedge Clk);
    Start = 1'b0;
    repeat (2) @(negedge Clk);
    Start = 1'b1; Nin = 8'd50; Din = 4'd3;
    @(negedge Clk);
    Start = 1'b0;
    c = 0;
    while (!Done && c < 40) begin @(negedge Clk); c++; end
    total++;
    if (!Done || Q !== 8'd14 || R !== 4'd2) begin
      bad++;
      $display("FAIL start_in_run: Done=%0b Q=%0d R=%0d, need 1 14 2", Done, Q, R);
    end
    // restart straight out of DONE
    Start = 1'b1; Nin = 8'd50; Din = 4'd3;
    @(negedge Clk);
    Start = 1'b0;
    total++;
    if (Done !== 1'b0 || Busy !== 1'b1) begin
      bad++;
      $display("FAIL restart_from_done: Done=%0b Busy=%0b, need 0 1", Done, Busy);
    end
    c = 1;
    while (!Done && c < 40) begin @(negedge Clk); c++; end
    total++;
    if (c != 9 || Q !== 8'd16 || R !== 4'd2) begin
      bad++;
      $display("FAIL restart_result: cycle=%0d Q=%0d R=%0d, need 9 16 2", c, Q, R);
    end
  endtask

  task automatic test_reset_mid_run();
    int c, b; bit tmo;
    @(negedge Clk);
    Start = 1'b1; Nin = 8'd100; Din = 4'd7;
    @(negedge Clk);
    Start = 1'b0;
    repeat (3) @(negedge Clk);
    #2 Resetn = 1'b0;
    #1;
    total++;
    if ({Q, R, Busy, Done, DivZero} !== 15'd0) begin
      bad++;
      $display("FAIL reset_mid_run: Q=%0d R=%0d B=%0b D=%0b, need all 0", Q, R, Busy, Done);
    end
    @(negedge Clk);
    Resetn = 1'b1;
    run_op(8'd9, 4'd2, c, b, tmo);
    total++;
    if (tmo || Q !== 8'd4 || R !== 4'd1 || c != 9) begin
      bad++;
      $display("FAIL after_reset: Q=%0d R=%0d cycle=%0d, need 4 1 9", Q, R, c);
    end
  endtask

  task automatic test_sweep();
    int c, b; bit tmo;
    logic [7:0] n; logic [3:0] d;
    logic [7:0] eq; logic [3:0] er; logic ez;
    for (int i = 0; i < 80; i++) begin
      n = 8'($urandom_range(0, 255));
      d = (i < 16) ? 4'(i) : 4'($urandom_range(0, 15));
      if (d == 0) begin eq = 8'hFF; er = 4'd0; ez = 1'b1; end
      else begin eq = 8'(int'(n) / int'(d)); er = 4'(int'(n) % int'(d)); ez = 1'b0; end
      run_op(n, d, c, b, tmo);
      total++;
      if (tmo || Q !== eq || R !== er || DivZero !== ez) begin
        bad++;
        $display("FAIL sweep: %0d/%0d gave Q=%0d R=%0d Z=%0b tmo=%0b, need %0d %0d %0b",
                 n, d, Q, R, DivZero, tmo, eq, er, ez);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_divzero();
    test_start_in_run();
    test_reset_mid_run();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
